// File: rtl/dac_row_loader.sv
// Row-code batch loader: collects up to ROWS codes, presents them on IDAC and runs the start/finish
// toggle handshake with the DAC driver. Define DAC_LOADER_PINGPONG_EN for a second fill bank.
module dac_row_loader #(
    parameter int               ROWS     = 8,
    parameter int               CODE_W   = 12,
    parameter logic [CODE_W-1:0] PAD_CODE = '0
) (
    input  logic                           clk,
    input  logic                           rstn,
    input  logic                           wr_valid,
    input  logic [CODE_W-1:0]              wr_data,
    input  logic                           wr_last,
    output logic                           wr_ready,
    output logic [ROWS-1:0][CODE_W-1:0]    IDAC,
    output logic                           start,
    input  logic                           finish,
    output logic                           busy,
    output logic                           batch_done,
    output logic [15:0]                    batch_cnt
);

    localparam int ROW_W = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam int LEN_W = $clog2(ROWS + 1);
`ifdef DAC_LOADER_PINGPONG_EN
    localparam int NB = 2;
`else
    localparam int NB = 1;
`endif

    typedef enum logic [1:0] {S_FILL, S_LOAD, S_LAUNCH, S_WAIT} state_t;

    state_t                        r_state;
    state_t                        w_state_next;
    logic [CODE_W-1:0]             r_bank [NB][ROWS];
    logic [LEN_W-1:0]              r_len  [NB];
    logic [ROW_W-1:0]              r_fill_idx;
    logic                          r_wr_ready;
    logic                          r_start;
    logic                          r_busy;
    logic                          r_done;
    logic [15:0]                   r_cnt;
    logic [ROWS-1:0][CODE_W-1:0]   r_idac;
    logic [ROWS-1:0][CODE_W-1:0]   w_idac_next;
    logic                          w_acc;
    logic                          w_close;
    logic                          w_fin;
    logic                          w_go_load;
    logic                          w_do_load;
    logic                          w_do_launch;
    logic                          w_do_done;
    logic                          w_ready_next;
    logic                          w_wsel;
    logic                          w_lsel;

    assign w_acc   = wr_valid && r_wr_ready;
    assign w_close = w_acc && (wr_last || (r_fill_idx == ROW_W'(ROWS - 1)));
    assign w_fin   = (finish == r_start);

`ifdef DAC_LOADER_PINGPONG_EN
    logic r_wsel;
    logic r_pend;
    logic w_pend_next;

    // The bank not being filled is always the one that was closed last.
    assign w_wsel    = r_wsel;
    assign w_lsel    = ~r_wsel;
    assign w_go_load = r_pend | w_close;

    always_comb begin
        w_pend_next = r_pend;
        if (w_do_done)
            w_pend_next = 1'b0;
        else if (w_close && (r_state != S_FILL))
            w_pend_next = 1'b1;
    end

    assign w_ready_next = ~w_pend_next;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_wsel <= 1'b0;
            r_pend <= 1'b0;
        end else begin
            r_pend <= w_pend_next;
            if (w_close)
                r_wsel <= ~r_wsel;
        end
    end
`else
    assign w_wsel       = 1'b0;
    assign w_lsel       = 1'b0;
    assign w_go_load    = 1'b0;
    assign w_ready_next = (w_state_next == S_FILL);
`endif

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn)
            r_state <= S_FILL;
        else
            r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_FILL:   if (w_close) w_state_next = S_LOAD;
            S_LOAD:   w_state_next = S_LAUNCH;
            S_LAUNCH: w_state_next = S_WAIT;
            S_WAIT:   if (w_fin) w_state_next = w_go_load ? S_LOAD : S_FILL;
            default:  w_state_next = S_FILL;
        endcase
    end

    always_comb begin
        w_do_load   = (r_state == S_LOAD);
        w_do_launch = (r_state == S_LAUNCH);
        w_do_done   = (r_state == S_WAIT) && w_fin;
    end

    // Data storage carries no reset; a bank is only read after a closing accept wrote its length.
    always_ff @(posedge clk) begin
        if (w_acc)
            r_bank[w_wsel][r_fill_idx] <= wr_data;
        if (w_close)
            r_len[w_wsel] <= LEN_W'(r_fill_idx) + LEN_W'(1);
    end

    genvar gi;
    generate
        for (gi = 0; gi < ROWS; gi++) begin : g_row
            assign w_idac_next[gi] = (LEN_W'(gi) < r_len[w_lsel]) ? r_bank[w_lsel][gi] : PAD_CODE;
        end
    endgenerate

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_fill_idx <= '0;
            r_wr_ready <= 1'b0;
            r_start    <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_cnt      <= '0;
            r_idac     <= '0;
        end else begin
            r_wr_ready <= w_ready_next;
            if (w_close)
                r_fill_idx <= '0;
            else if (w_acc)
                r_fill_idx <= r_fill_idx + ROW_W'(1);
            if (w_do_load)
                r_idac <= w_idac_next;
            if (w_do_launch) begin
                r_start <= ~r_start;
                r_busy  <= 1'b1;
            end
            r_done <= w_do_done;
            if (w_do_done) begin
                r_busy <= 1'b0;
                r_cnt  <= r_cnt + 16'd1;
            end
        end
    end

    assign wr_ready   = r_wr_ready;
    assign IDAC       = r_idac;
    assign start      = r_start;
    assign busy       = r_busy;
    assign batch_done = r_done;
    assign batch_cnt  = r_cnt;

endmodule

// File: tb/tb_dac_row_loader.sv
// Directed bench for dac_row_loader with a toggle-handshake DAC driver model answering on the
// falling edge; expectations follow DAC_LOADER_PINGPONG_EN when it is defined.
module tb_dac_row_loader;

`ifdef DAC_LOADER_PINGPONG_EN
    localparam bit PP = 1'b1;
`else
    localparam bit PP = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              rstn = 1'b0;
    logic              wr_valid = 1'b0;
    logic [11:0]       wr_data = 12'h000;
    logic              wr_last = 1'b0;
    logic              wr_ready;
    logic [7:0][11:0]  idac;
    logic              start;
    logic              finish;
    logic              busy;
    logic              batch_done;
    logic [15:0]       batch_cnt;

    int n_chk = 0;
    int n_bad = 0;
    int dac_delay = 2;
    int dly;
    int acc_total = 0;

    always #5 clk = ~clk;

    dac_row_loader dut (
        .clk        (clk),
        .rstn       (rstn),
        .wr_valid   (wr_valid),
        .wr_data    (wr_data),
        .wr_last    (wr_last),
        .wr_ready   (wr_ready),
        .IDAC       (idac),
        .start      (start),
        .finish     (finish),
        .busy       (busy),
        .batch_done (batch_done),
        .batch_cnt  (batch_cnt)
    );

    // DAC driver model: answers dac_delay+1 falling edges after start moves away from finish.
    always @(negedge clk or negedge rstn) begin
        if (!rstn) begin
            finish <= 1'b0;
            dly    <= 0;
        end else if (start != finish) begin
            if (dly >= dac_delay) begin
                finish <= ~finish;
                dly    <= 0;
            end else begin
                dly <= dly + 1;
            end
        end
    end

    always @(posedge clk)
        if (wr_valid && wr_ready)
            acc_total <= acc_total + 1;

    task automatic check_val(input string tag, input logic [95:0] got, input logic [95:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0][11:0] mk_rows(input logic [11:0] base, input int n);
        logic [7:0][11:0] r;
        for (int i = 0; i < 8; i++)
            r[i] = (i < n) ? base + 12'(i + 1) : 12'h000;
        return r;
    endfunction

    task automatic send_word(input logic [11:0] d, input logic l);
        int n = 0;
        @(negedge clk);
        wr_valid = 1'b1;
        wr_data  = d;
        wr_last  = l;
        while (wr_ready !== 1'b1 && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200)
            check_val("send_timeout", wr_ready, 1'b1);
        @(posedge clk);
        #1;
        wr_valid = 1'b0;
        wr_last  = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        int n = 0;
        while (batch_done !== 1'b1 && n < 200) begin
            @(posedge clk);
            #1;
            n++;
        end
        check_val({tag, "_done"}, batch_done, 1'b1);
        $display("batch %s: cnt=%0d start=%0b idac0=%h", tag, batch_cnt, start, idac[0]);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [7:0][11:0] e;
        int acc_base;

        repeat (2) @(posedge clk);
        #1;
        check_val("rst_ready", wr_ready, 1'b0);
        check_val("rst_start", start, 1'b0);
        check_val("rst_busy", busy, 1'b0);
        check_val("rst_done", batch_done, 1'b0);
        check_val("rst_cnt", batch_cnt, 16'd0);
        check_val("rst_idac", idac, 96'd0);
        @(negedge clk);
        rstn = 1'b1;
        @(posedge clk);
        #1;
        check_val("ready_after_rst", wr_ready, 1'b1);

        // Full 8-word batch.
        dac_delay = 3;
        for (int i = 0; i < 8; i++)
            send_word(12'(i + 1), 1'b0);
        check_val("t1_ready_load", wr_ready, PP);
        check_val("t1_start_n", start, 1'b0);
        @(posedge clk);
        #1;
        check_val("t1_start_n1", start, 1'b0);
        check_val("t1_idac", idac, mk_rows(12'h000, 8));
        @(posedge clk);
        #1;
        check_val("t1_start_n2", start, 1'b1);
        check_val("t1_busy_n2", busy, 1'b1);
        @(posedge clk);
        #1;
        check_val("t1_busy_n3", busy, 1'b1);
        wait_done("t1");
        check_val("t1_cnt", batch_cnt, 16'd1);
        check_val("t1_busy_end", busy, 1'b0);
        @(posedge clk);
        #1;
        check_val("t1_done_pulse", batch_done, 1'b0);

        // Short batch closed by wr_last, padded rows.
        send_word(12'hABC, 1'b0);
        send_word(12'h123, 1'b0);
        send_word(12'hFFF, 1'b1);
        @(posedge clk);
        #1;
        e = '0;
        e[0] = 12'hABC;
        e[1] = 12'h123;
        e[2] = 12'hFFF;
        check_val("t2_idac", idac, e);
        wait_done("t2");
        check_val("t2_cnt", batch_cnt, 16'd2);
        check_val("t2_start", start, 1'b0);
        @(posedge clk);
        #1;

        // Back-to-back 8-word batches.
        dac_delay = 10;
        acc_base = acc_total;
        fork
            begin
                for (int i = 0; i < 16; i++)
                    send_word((i < 8) ? 12'(12'h101 + i) : 12'(12'h201 + i - 8), 1'b0);
            end
            begin
                wait_done("t3a");
                check_val("t3_acc_at_done1", acc_total - acc_base, PP ? 16 : 8);
                check_val("t3_idac_hold", idac, mk_rows(12'h100, 8));
                @(posedge clk);
                #1;
                wait_done("t3b");
            end
        join
        check_val("t3_idac2", idac, mk_rows(12'h200, 8));
        check_val("t3_start", start, 1'b0);
        check_val("t3_cnt", batch_cnt, 16'd4);
        @(posedge clk);
        #1;

        // Reset while waiting for the driver.
        dac_delay = 1000;
        send_word(12'h777, 1'b1);
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        check_val("t4_start_pre", start, 1'b1);
        check_val("t4_busy_pre", busy, 1'b1);
        @(posedge clk);
        #1;
        @(negedge clk);
        rstn = 1'b0;
        #1;
        check_val("t4_rst_start", start, 1'b0);
        check_val("t4_rst_busy", busy, 1'b0);
        check_val("t4_rst_cnt", batch_cnt, 16'd0);
        check_val("t4_rst_idac", idac, 96'd0);
        check_val("t4_rst_ready", wr_ready, 1'b0);
        check_val("t4_rst_done", batch_done, 1'b0);
        @(negedge clk);
        rstn = 1'b1;
        dac_delay = 2;
        send_word(12'h5A5, 1'b1);
        wait_done("t4");
        check_val("t4_cnt", batch_cnt, 16'd1);
        check_val("t4_idac", idac, {84'd0, 12'h5A5});
        @(posedge clk);
        #1;

        // Counter wrap.
        @(negedge clk);
        force dut.r_cnt = 16'hFFFF;
        @(negedge clk);
        release dut.r_cnt;
        #1;
        check_val("t5_cnt_pre", batch_cnt, 16'hFFFF);
        send_word(12'h042, 1'b1);
        wait_done("t5");
        check_val("t5_cnt_wrap", batch_cnt, 16'h0000);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule

// File: doc/dac_row_loader.md
# dac_row_loader

Upstream feeder for the 8-row serial input-DAC driver. Accepts 12-bit row codes from the host/controller as a valid/ready word stream, assembles them into one batch of `ROWS` codes, and presents the batch on a stable parallel `IDAC` bus. Launches the DAC driver with the toggle handshake (DAC busy while `start != finish`) and waits for completion before releasing the bus. Tracks completed batches for the controller.

## Interface
- `ROWS`, 8, rows per batch; equals the DAC driver's open-row count.
- `CODE_W`, 12, DAC code width.
- `PAD_CODE`, 12'd0, code driven on rows not supplied in a short batch.
- `clk`  input  1  system clock, shared with the DAC driver.
- `rstn`  input  1  asynchronous active-low reset.
- `wr_valid`  input  1  host word valid.
- `wr_data`  input  CODE_W  row code.
- `wr_last`  input  1  word closes the batch early.
- `wr_ready`  output  1  loader accepts a word this cycle.
- `IDAC`  output  ROWS x CODE_W  registered row codes to the DAC driver.
- `start`  output  1  launch toggle to the DAC driver.
- `finish`  input  1  completion toggle from the DAC driver.
- `busy`  output  1  a DAC transfer is in flight.
- `batch_done`  output  1  one-cycle pulse per completed DAC transfer.
- `batch_cnt`  output  16  completed transfers, wraps at 16'hFFFF -> 0.

## Operation
- States: FILL, LOAD, LAUNCH, WAIT.
- FILL:
  - `wr_ready=1`.
  - An accepted word (`wr_valid && wr_ready` at posedge) goes to fill-bank row `fill_idx`, and `fill_idx` increments.
  - The batch closes on the accept of row `ROWS-1`, or on any accept with `wr_last=1`.
  - A closing accept moves to LOAD.
- LOAD (1 cycle):
  - `IDAC` is loaded from the fill bank.
  - Rows at index >= the number of accepted words take `PAD_CODE`.
  - `fill_idx` clears.
- LAUNCH (1 cycle): `start <= ~start`, `busy <= 1`.
- WAIT:
  - Holds until sampled `finish == start`.
  - Then `busy <= 0`, a one-cycle `batch_done` pulse, and `batch_cnt+1`.
  - Next state is FILL, or LOAD if a pending batch is ready (see Configuration).
- `IDAC` is constant from LOAD through the end of WAIT.
- A batch always holds at least one word. Empty batches are impossible.
- A `wr_valid` held high while `wr_ready=0` is not consumed, and `wr_data` is not sampled.
- `finish` is driven on the falling edge. The loader samples it on the rising edge; no synchronizer.

## Timing
- Reset values: `IDAC` all 0, `start=0`, `busy=0`, `batch_done=0`, `batch_cnt=0`, `wr_ready=0`, state FILL. `wr_ready` goes to 1 on the first clock after reset release.
- Closing accept at edge N: LOAD at edge N+1, `start` toggles at edge N+2.
- `batch_done` is high for the cycle after the edge that sees `finish == start`.
- Reset mid-transfer returns everything to reset values. The DAC driver shares `rstn`, so `finish` returns to 0 and the handshake stays aligned.
- `start` toggles at most once per batch. It never toggles while `busy=1`.

## Configuration
- `DAC_LOADER_PINGPONG_EN` defined:
  - Two fill banks. `wr_ready=1` during LOAD/LAUNCH/WAIT as long as the alternate bank is not closed.
  - A batch closed during WAIT is pending. On completion, the loader goes directly to LOAD with the pending bank, skipping FILL.
  - `wr_ready=0` once the pending bank is closed, until its LOAD.
- Not defined:
  - Single bank. `wr_ready=1` only in FILL.
  - Words offered during LOAD/LAUNCH/WAIT stall.

## Test plan
- 8 words 12'h001..12'h008, no `wr_last` -> `IDAC[0..7]=1..8`, `start` 0->1 two cycles after the 8th accept, `busy=1` until `finish` toggles, then `batch_done` pulse and `batch_cnt=1`.
- 3 words 12'hABC, 12'h123, 12'hFFF with `wr_last` on the third, `PAD_CODE=0` -> `IDAC=[ABC,123,FFF,0,0,0,0,0]`, one transfer.
- Two back-to-back 8-word batches, pingpong disabled -> `wr_ready=0` throughout the first transfer, second batch fully accepted after the first `batch_done`, `start` ends at 0, `batch_cnt=2`.
- Same stimulus with `DAC_LOADER_PINGPONG_EN` -> second batch fully accepted during WAIT, LOAD follows the first `batch_done` immediately, `IDAC` unchanged until that LOAD.
- `rstn` asserted in WAIT with `start=1` -> all outputs at reset values, a following 1-word batch (`wr_last`) completes normally with `batch_cnt=1`.
- Preload `batch_cnt` path to 16'hFFFF via 65535 one-word batches (or forced) -> next completion reads 0.
